// File: rtl/dmem_arbiter.sv
// Shares one data memory between the processor load/store port (0) and the
// host/debug loader port (1): round-robin grant, routed access, registered read return.
module dmem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // Handshake: rN_req acts as valid and rN_gnt as ready. A requester keeps
  // req/we/addr/wdata stable until it sees gnt high at a rising edge; the
  // access is performed in exactly that cycle, so holding req high yields one
  // access per cycle when uncontested.

  logic              last_q;   // index of the most recently granted port
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              gnt0;
  logic              gnt1;

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (RST) begin
      // Under contention the port that did not win last time goes first.
      if (r0_req && (!r1_req || last_q)) begin
        gnt0 = 1'b1;
      end else if (r1_req) begin
        gnt1 = 1'b1;
      end
    end
    if (gnt0) begin
      mem_we    = r0_we;
      mem_addr  = r0_addr;
      mem_wdata = r0_wdata;
    end else if (gnt1) begin
      mem_we    = r1_we;
      mem_addr  = r1_addr;
      mem_wdata = r1_wdata;
    end
  end

  assign r0_gnt = gnt0;
  assign r1_gnt = gnt1;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      last_q       <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      r0_rvalid    <= 1'b0;
      r1_rvalid    <= 1'b0;
      r0_rdata     <= '0;
      r1_rdata     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt0 || gnt1) begin
        last_q  <= gnt1;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      r0_rvalid <= gnt0 && !r0_we;
      r1_rvalid <= gnt1 && !r1_we;
      if (gnt0 && !r0_we) begin
        r0_rdata <= mem_rdata;
      end
      if (gnt1 && !r1_we) begin
        r1_rdata <= mem_rdata;
      end
      if (r0_req && r1_req && !(&conflict_cnt)) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  req_known: assert property (@(posedge CLK) RST |-> !$isunknown({r0_req, r1_req}));
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level reference model and a read-return scoreboard.
module tb_dmem_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  // clock / reset
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic          p_req [2];
  logic          p_we  [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];

  logic          r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_req, r1_we, r1_gnt, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] conflict_cnt;

  assign r0_req = p_req[0];
  assign r0_we = p_we[0];
  assign r0_addr = p_addr[0];
  assign r0_wdata = p_wdata[0];
  assign r1_req = p_req[1];
  assign r1_we = p_we[1];
  assign r1_addr = p_addr[1];
  assign r1_wdata = p_wdata[1];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // data memory the arbiter drives
  logic [DW-1:0] mem [128];
  assign mem_rdata = mem[mem_addr];
  always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // reference model state
  logic [DW-1:0] ref_mem [128];
  int            m_last;
  logic [CW-1:0] m_cnt;
  logic          hold_ok;
  logic [AW-1:0] m_haddr;
  logic [DW-1:0] m_hwdata;
  logic [DW-1:0] m_rdata0, m_rdata1;
  logic          done [2];
  int            rand_mode;
  txn_t          txq0[$], txq1[$];
  int            obs_q[$];

  // scoreboard
  logic [DW-1:0] exp0_q[$], exp1_q[$];
  int            due0_q[$], due1_q[$];

  int n_vec = 0;
  int n_err = 0;
  int pat [7] = '{1, 2, 1, 2, 1, 2, 1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // driver tasks
  task automatic load_txn(input int i, input txn_t t);
    p_req[i] = 1'b1;
    p_we[i] = t.we;
    p_addr[i] = t.addr;
    p_wdata[i] = t.wdata;
  endtask

  task automatic apply_updates();
    txn_t t;
    for (int i = 0; i < 2; i++) begin
      if (done[i]) begin
        p_req[i] = 1'b0;
        done[i] = 1'b0;
      end
      if (!p_req[i]) begin
        if (i == 0 && txq0.size() > 0) load_txn(0, txq0.pop_front());
        else if (i == 1 && txq1.size() > 0) load_txn(1, txq1.pop_front());
        else if (rand_mode == 1 && $urandom_range(0, 9) < 6) begin
          t.we = 1'($urandom_range(0, 1));
          t.addr = AW'($urandom_range(0, 15));
          t.wdata = $urandom;
          load_txn(i, t);
        end else if (rand_mode == 2) begin
          t.we = 1'b0;
          t.addr = AW'($urandom_range(0, 127));
          t.wdata = $urandom;
          load_txn(i, t);
        end
      end
    end
  endtask

  task automatic push_txn(input int i, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
    txn_t t;
    t.we = we;
    t.addr = addr;
    t.wdata = wdata;
    if (i == 0) txq0.push_back(t);
    else txq1.push_back(t);
  endtask

  // One clock cycle: drive, predict from the model, compare, advance the model.
  task automatic step(input logic rst_v);
    int   eg;
    logic exp_we;
    @(negedge CLK);
    RST = rst_v;
    apply_updates();
    #1;
    eg = -1;
    if (rst_v) begin
      if (p_req[0] && p_req[1]) eg = 1 - m_last;
      else if (p_req[0]) eg = 0;
      else if (p_req[1]) eg = 1;
    end
    exp_we = 1'b0;
    if (eg >= 0) exp_we = p_we[eg];
    check("r0_gnt", r0_gnt, eg == 0);
    check("r1_gnt", r1_gnt, eg == 1);
    check("mem_we", mem_we, exp_we);
    obs_q.push_back(int'({r1_gnt, r0_gnt}));
    if (eg >= 0) begin
      check("mem_addr", mem_addr, p_addr[eg]);
      check("mem_wdata", mem_wdata, p_wdata[eg]);
    end else if (rst_v && hold_ok) begin
      check("mem_addr_hold", mem_addr, m_haddr);
      check("mem_wdata_hold", mem_wdata, m_hwdata);
    end
    check("conflict_cnt", conflict_cnt, m_cnt);
    if (!rst_v) begin
      m_last = 1;
      m_cnt = '0;
      hold_ok = 1'b0;
      m_rdata0 = '0;
      m_rdata1 = '0;
      exp0_q.delete(); exp1_q.delete(); due0_q.delete(); due1_q.delete();
    end else begin
      if (p_req[0] && p_req[1] && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      if (eg >= 0) begin
        if (p_we[eg]) ref_mem[p_addr[eg]] = p_wdata[eg];
        else if (eg == 0) begin
          exp0_q.push_back(ref_mem[p_addr[0]]);
          due0_q.push_back(cyc + 1);
        end else begin
          exp1_q.push_back(ref_mem[p_addr[1]]);
          due1_q.push_back(cyc + 1);
        end
        m_last = eg;
        hold_ok = 1'b1;
        m_haddr = p_addr[eg];
        m_hwdata = p_wdata[eg];
        done[eg] = 1'b1;
      end
    end
  endtask

  // monitor: read returns are popped from the scoreboard as the DUT presents them
  always @(posedge CLK) begin
    #1;
    if (RST !== 1'b1) begin
      check("rst_r0_rvalid", r0_rvalid, 1'b0);
      check("rst_r1_rvalid", r1_rvalid, 1'b0);
      check("rst_r0_rdata", r0_rdata, '0);
      check("rst_r1_rdata", r1_rdata, '0);
    end else begin
      if (r0_rvalid) begin
        if (due0_q.size() == 0 || due0_q[0] != cyc) check("r0_rvalid_unexpected", r0_rvalid, 1'b0);
        else begin
          void'(due0_q.pop_front());
          m_rdata0 = exp0_q.pop_front();
          check("r0_rdata", r0_rdata, m_rdata0);
        end
      end else begin
        if (due0_q.size() > 0 && due0_q[0] <= cyc) begin
          check("r0_rvalid_missing", r0_rvalid, 1'b1);
          void'(due0_q.pop_front());
          void'(exp0_q.pop_front());
        end
        check("r0_rdata_hold", r0_rdata, m_rdata0);
      end
      if (r1_rvalid) begin
        if (due1_q.size() == 0 || due1_q[0] != cyc) check("r1_rvalid_unexpected", r1_rvalid, 1'b0);
        else begin
          void'(due1_q.pop_front());
          m_rdata1 = exp1_q.pop_front();
          check("r1_rdata", r1_rdata, m_rdata1);
        end
      end else begin
        if (due1_q.size() > 0 && due1_q[0] <= cyc) begin
          check("r1_rvalid_missing", r1_rvalid, 1'b1);
          void'(due1_q.pop_front());
          void'(exp1_q.pop_front());
        end
        check("r1_rdata_hold", r1_rdata, m_rdata1);
      end
    end
  end

  initial begin
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p_req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0; done[i] = 1'b0;
    end
    for (int i = 0; i < 128; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    m_last = 1; m_cnt = '0; hold_ok = 1'b0; m_rdata0 = '0; m_rdata1 = '0;
    rand_mode = 0;

    // write then read back on port 0
    step(1'b0); step(1'b0);
    obs_q.delete();
    push_txn(0, 1'b1, 7'd5, 32'hDEADBEEF);
    push_txn(0, 1'b0, 7'd5, 32'h0);
    repeat (4) step(1'b1);
    check("t1_gnt_c0", obs_q[0], 1);
    check("t1_gnt_c1", obs_q[1], 1);
    check("t1_idle_c2", obs_q[2], 0);
    check("t1_r0_rdata", r0_rdata, 32'hDEADBEEF);

    // first conflict after reset
    step(1'b0);
    obs_q.delete();
    push_txn(0, 1'b0, 7'd1, 32'h0);
    push_txn(1, 1'b0, 7'd2, 32'h0);
    repeat (3) step(1'b1);
    check("t2_first_gnt", obs_q[0], 1);
    check("t2_second_gnt", obs_q[1], 2);
    check("t2_cnt", conflict_cnt, 1);

    // continuous contention
    step(1'b0);
    obs_q.delete();
    repeat (4) push_txn(0, 1'b0, AW'($urandom_range(0, 127)), 32'h0);
    repeat (3) push_txn(1, 1'b0, AW'($urandom_range(0, 127)), 32'h0);
    repeat (7) step(1'b1);
    for (int i = 0; i < 7; i++) check("t3_gnt_seq", obs_q[i], pat[i]);
    check("t3_cnt", conflict_cnt, 6);
    repeat (2) step(1'b1);

    // read then write same address on consecutive cycles
    push_txn(0, 1'b1, 7'd9, 32'h11);
    repeat (2) step(1'b1);
    push_txn(1, 1'b0, 7'd9, 32'h0);
    step(1'b1);
    push_txn(0, 1'b1, 7'd9, 32'h22);
    step(1'b1);
    check("t4_pre_write_data", r1_rdata, 32'h11);
    push_txn(1, 1'b0, 7'd9, 32'h0);
    repeat (3) step(1'b1);
    check("t4_post_write_data", r1_rdata, 32'h22);

    // reset right after a granted read
    push_txn(0, 1'b0, 7'd3, 32'h0);
    step(1'b1);
    step(1'b0);
    repeat (3) step(1'b1);
    obs_q.delete();
    push_txn(0, 1'b0, 7'd4, 32'h0);
    push_txn(1, 1'b0, 7'd5, 32'h0);
    step(1'b1);
    check("t5_gnt_after_reset", obs_q[0], 1);
    repeat (3) step(1'b1);

    // random traffic with occasional resets
    rand_mode = 1;
    repeat (2000) step(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0);
    rand_mode = 0;
    repeat (4) step(1'b1);

    // counter saturation
    step(1'b0);
    rand_mode = 2;
    repeat (32'hFFFE + 3) step(1'b1);
    rand_mode = 0;
    step(1'b1);
    check("t6_cnt_sat", conflict_cnt, 16'hFFFF);
    repeat (3) step(1'b1);
    check("t6_cnt_held", conflict_cnt, 16'hFFFF);

    check("drain", due0_q.size() + due1_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
